// File: rtl/core_pkg.sv
// Shared encodings for the multicycle core: opcode/funct constants, FSM states
// and ALU operations.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR
  } alu_op_e;

endpackage

// File: rtl/core_alu.sv
// Combinational ALU; the zero flag doubles as the BEQ equality test (SUB).
module core_alu
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    case (op)
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV32-subset core: FETCH/DECODE/EXEC/MEM/WB with a local register
// file and request/valid memory ports.
module multicycle_core
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_valid,
  output logic            halted
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [XLEN-1:0] alu_q, alu_d, ld_q, ld_d;
  logic [31:0]     ir_q, ir_d;
  logic            imem_req_q, imem_req_d, dmem_req_q, dmem_req_d;
  logic            halted_q, halted_d;

  logic [XLEN-1:0] rf_q [NREG];
  logic            rf_we;
  logic [XLEN-1:0] rf_wdata;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd_f, rs1_f, rs2_f;
  assign opcode = ir_q[6:0];
  assign rd_f   = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1_f  = ir_q[19:15];
  assign rs2_f  = ir_q[24:20];
  assign f7     = ir_q[31:25];

  function automatic logic reg_ok(input logic [4:0] idx);
    return {27'b0, idx} < 32'(NREG);
  endfunction

  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

  logic legal;
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R:      legal = ((f7 == F7_BASE && (f3 == F3_ADDSUB || f3 == F3_OR || f3 == F3_AND)) ||
                          (f7 == F7_SUB && f3 == F3_ADDSUB)) &&
                         reg_ok(rd_f) && reg_ok(rs1_f) && reg_ok(rs2_f);
      OP_IMM:    legal = (f3 == F3_ADDSUB) && reg_ok(rd_f) && reg_ok(rs1_f);
      OP_LOAD:   legal = (f3 == F3_WORD) && reg_ok(rd_f) && reg_ok(rs1_f);
      OP_STORE:  legal = (f3 == F3_WORD) && reg_ok(rs1_f) && reg_ok(rs2_f);
      OP_BRANCH: legal = (f3 == F3_BEQ) && reg_ok(rs1_f) && reg_ok(rs2_f);
      default:   legal = 1'b0;
    endcase
  end

  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_b, alu_res;
  logic            alu_zero;
  always_comb begin
    alu_op = ALU_ADD;
    if (opcode == OP_BRANCH) alu_op = ALU_SUB;
    else if (opcode == OP_R) begin
      case (f3)
        F3_OR:   alu_op = ALU_OR;
        F3_AND:  alu_op = ALU_AND;
        default: alu_op = f7[5] ? ALU_SUB : ALU_ADD;
      endcase
    end
  end
  assign alu_b = (opcode == OP_R || opcode == OP_BRANCH) ? rs2_q : imm_q;

  core_alu #(.XLEN(XLEN)) u_alu (
    .op(alu_op), .a(rs1_q), .b(alu_b), .result(alu_res), .zero(alu_zero)
  );

  logic [XLEN-1:0] pc_inc, br_tgt;
  assign pc_inc = pc_q + XLEN'(4);
  assign br_tgt = pc_q + imm_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    imm_d      = imm_q;
    alu_d      = alu_q;
    ld_d       = ld_q;
    imem_req_d = 1'b0;
    dmem_req_d = 1'b0;
    halted_d   = halted_q;
    rf_we      = 1'b0;
    rf_wdata   = (opcode == OP_LOAD) ? ld_q : alu_q;
    case (state_q)
      S_FETCH: begin
        imem_req_d = 1'b1;
        // The request flop is low for one cycle after reset; ignore stray valids then.
        if (imem_req_q && imem_valid) begin
          ir_d       = imem_rdata;
          imem_req_d = 1'b0;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        rs1_d = rf_q[ir_q[15 +: RW]];
        rs2_d = rf_q[ir_q[20 +: RW]];
        imm_d = (opcode == OP_STORE) ? imm_s : (opcode == OP_BRANCH) ? imm_b : imm_i;
        if (legal) state_d = S_EXEC;
        else begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end
      end
      S_EXEC: begin
        alu_d = alu_res;
        if (opcode == OP_LOAD || opcode == OP_STORE) begin
          state_d    = S_MEM;
          dmem_req_d = 1'b1;
        end else if (opcode == OP_BRANCH) begin
          if (alu_zero && br_tgt[1:0] != 2'b00) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d       = alu_zero ? br_tgt : pc_inc;
            state_d    = S_FETCH;
            imem_req_d = 1'b1;
          end
        end else state_d = S_WB;
      end
      S_MEM: begin
        dmem_req_d = 1'b1;
        if (dmem_valid) begin
          dmem_req_d = 1'b0;
          if (opcode == OP_LOAD) begin
            ld_d    = dmem_rdata;
            state_d = S_WB;
          end else begin
            pc_d       = pc_inc;
            state_d    = S_FETCH;
            imem_req_d = 1'b1;
          end
        end
      end
      S_WB: begin
        rf_we      = (rd_f != 5'd0);
        pc_d       = pc_inc;
        state_d    = S_FETCH;
        imem_req_d = 1'b1;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      alu_q      <= '0;
      ld_q       <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      imm_q      <= imm_d;
      alu_q      <= alu_d;
      ld_q       <= ld_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      halted_q   <= halted_d;
    end
  end

  // x0 is never written, so its reset value keeps it reading as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[ir_q[7 +: RW]] <= rf_wdata;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = (opcode == OP_STORE);
  assign dmem_addr  = alu_q;
  assign dmem_wdata = rs2_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed programs for multicycle_core; a monitor checks every fetch and data
// access against expectation queues filled when each program is loaded.
module tb_multicycle_core;

  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_valid, dmem_req, dmem_we, dmem_valid, halted;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int imem_delay = 0, dmem_delay = 0, icnt = 0, dcnt = 0, cyc = 0;
  int checks = 0, failures = 0, rel = 0, dreq_len = 0;
  bit dmem_hold = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
  } dexp_t;

  logic [31:0] exp_fetch[$];
  dexp_t       exp_d[$];
  int          fetch_t[$];

  multicycle_core #(.XLEN(32), .NREG(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr[7:2]];
  assign imem_valid = imem_req && (icnt >= imem_delay);
  assign dmem_rdata = dmem[dmem_addr[7:2]];
  assign dmem_valid = dmem_req && !dmem_hold && (dcnt >= dmem_delay);

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    icnt <= (imem_req && !imem_valid) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_valid) ? dcnt + 1 : 0;
    if (dmem_req && dmem_valid && dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    dexp_t e;
    if (imem_req && dmem_req) chk("req_exclusive", {31'b0, dmem_req}, 32'd0);
    if (dmem_req) dreq_len++;
    else dreq_len = 0;
    if (imem_req && imem_valid) begin
      fetch_t.push_back(cyc);
      if (exp_fetch.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_fetch: got addr %h expected none", imem_addr);
      end else chk("fetch_addr", imem_addr, exp_fetch.pop_front());
    end
    if (dmem_req && dmem_valid) begin
      if (exp_d.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_dmem: got addr %h expected none", dmem_addr);
      end else begin
        e = exp_d.pop_front();
        chk("dmem_we", {31'b0, dmem_we}, {31'b0, e.we});
        chk("dmem_addr", dmem_addr, e.addr);
        if (e.we) chk("dmem_wdata", dmem_wdata, e.wdata);
        chk("dmem_req_cycles", dreq_len, e.hold);
      end
    end
  end

  function automatic logic [31:0] r_type(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    logic [31:0] a, b, c, d, e;
    a = f7; b = rs2; c = rs1; d = f3; e = rd;
    return {a[6:0], b[4:0], c[4:0], d[2:0], e[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input int imm, input int rs1, input int f3, input int rd, input int op);
    logic [31:0] i, c, d, e, o;
    i = imm; c = rs1; d = f3; e = rd; o = op;
    return {i[11:0], c[4:0], d[2:0], e[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] s_type(input int imm, input int rs2, input int rs1);
    logic [31:0] i, b, c;
    i = imm; b = rs2; c = rs1;
    return {i[11:5], b[4:0], c[4:0], 3'b010, i[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_type(input int imm, input int rs2, input int rs1);
    logic [31:0] i, b, c;
    i = imm; b = rs2; c = rs1;
    return {i[12], i[10:5], b[4:0], c[4:0], 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic int ft(input int i);
    return (i < fetch_t.size()) ? fetch_t[i] : -10000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    dexp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.hold = hold;
    exp_d.push_back(e);
  endtask

  task automatic start_reset();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_pc", imem_addr, RST_PC);
    fetch_t.delete();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000007F;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    rel = cyc;
  endtask

  task automatic wait_halt(input int lim);
    int n = 0;
    while (halted !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk("halted", {31'b0, halted}, 32'd1);
  endtask

  task automatic end_phase();
    chk("fetch_queue_drained", exp_fetch.size(), 32'd0);
    chk("dmem_queue_drained", exp_d.size(), 32'd0);
    exp_fetch.delete();
    exp_d.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Phase 1: ALU ops, SW/LW with 3-cycle data wait, x0 semantics, branches.
    dmem_delay = 3;
    imem_delay = 0;
    start_reset();
    imem[0]  = i_type(5, 0, 0, 1, 'h13);       // addi x1,x0,5
    imem[1]  = r_type(0, 1, 1, 0, 2);          // add  x2,x1,x1
    imem[2]  = s_type(4, 2, 0);                // sw   x2,4(x0)
    imem[3]  = i_type(4, 0, 2, 3, 'h03);       // lw   x3,4(x0)
    imem[4]  = s_type(8, 3, 0);                // sw   x3,8(x0)
    imem[5]  = r_type('h20, 1, 3, 0, 5);       // sub  x5,x3,x1
    imem[6]  = i_type(12, 0, 0, 8, 'h13);      // addi x8,x0,12
    imem[7]  = r_type(0, 1, 8, 6, 7);          // or   x7,x8,x1
    imem[8]  = r_type(0, 1, 8, 7, 6);          // and  x6,x8,x1
    imem[9]  = s_type(12, 5, 0);               // sw   x5,12(x0)
    imem[10] = s_type(16, 7, 0);               // sw   x7,16(x0)
    imem[11] = s_type(20, 6, 0);               // sw   x6,20(x0)
    imem[12] = i_type(9, 0, 0, 4, 'h13);       // addi x4,x0,9
    imem[13] = i_type(7, 0, 0, 0, 'h13);       // addi x0,x0,7
    imem[14] = r_type(0, 0, 0, 0, 4);          // add  x4,x0,x0
    imem[15] = s_type(24, 4, 0);               // sw   x4,24(x0)
    imem[16] = i_type(-1, 0, 0, 9, 'h13);      // addi x9,x0,-1
    imem[17] = i_type(2, 9, 0, 10, 'h13);      // addi x10,x9,2
    imem[18] = s_type(28, 9, 0);               // sw   x9,28(x0)
    imem[19] = s_type(32, 10, 0);              // sw   x10,32(x0)
    imem[20] = b_type(8, 1, 1);                // beq  x1,x1,+8
    imem[22] = b_type(8, 2, 1);                // beq  x1,x2,+8 (not taken)
    imem[23] = i_type(-4, 8, 2, 11, 'h03);     // lw   x11,-4(x8)
    imem[24] = s_type(36, 11, 0);              // sw   x11,36(x0)
    for (int a = 0; a <= 'h50; a += 4) exp_fetch.push_back(a);
    exp_fetch.push_back(32'h58); exp_fetch.push_back(32'h5C);
    exp_fetch.push_back(32'h60); exp_fetch.push_back(32'h64);
    push_d(1, 4, 10, 4);
    push_d(0, 4, 0, 4);
    push_d(1, 8, 10, 4);
    push_d(1, 12, 5, 4);
    push_d(1, 16, 13, 4);
    push_d(1, 20, 4, 4);
    push_d(1, 24, 0, 4);
    push_d(1, 28, 32'hFFFF_FFFF, 4);
    push_d(1, 32, 1, 4);
    push_d(0, 8, 0, 4);
    push_d(1, 36, 10, 4);
    release_reset();
    tick();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    wait_halt(1500);
    chk("t_first_fetch", ft(0) - rel, 1);
    chk("t_add_retire", ft(2) - rel, 9);
    chk("t_sw_wait3", ft(3) - ft(2), 7);
    chk("t_lw_wait3", ft(4) - ft(3), 8);
    chk("t_beq", ft(21) - ft(20), 3);
    chk("halt_pc_p1", imem_addr, 32'h64);
    end_phase();

    // Phase 2: branches with 2-cycle fetch wait, then sustained halt.
    dmem_delay = 0;
    imem_delay = 2;
    start_reset();
    imem[0] = i_type(1, 0, 0, 1, 'h13);        // addi x1,x0,1
    imem[1] = b_type(12, 0, 0);                // beq  x0,x0,+12 -> 0x10
    imem[4] = b_type(-8, 1, 1);                // beq  x1,x1,-8  -> 0x08
    imem[2] = b_type(8, 0, 1);                 // beq  x1,x0,+8  -> 0x0C
    exp_fetch.push_back(32'h00); exp_fetch.push_back(32'h04);
    exp_fetch.push_back(32'h10); exp_fetch.push_back(32'h08);
    exp_fetch.push_back(32'h0C);
    release_reset();
    wait_halt(300);
    chk("t_first_fetch_wait2", ft(0) - rel, 3);
    chk("t_addi_wait2", ft(1) - ft(0), 6);
    chk("t_beq_wait2", ft(3) - ft(2), 5);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_imem_req", {31'b0, imem_req}, 32'd0);
      chk("halt_pc", imem_addr, 32'h0C);
    end
    end_phase();

    // Phase 3: taken branch to a misaligned target halts without moving the PC.
    imem_delay = 0;
    start_reset();
    imem[0] = i_type(1, 0, 0, 1, 'h13);        // addi x1,x0,1
    imem[1] = b_type(6, 1, 1);                 // beq  x1,x1,+6 -> misaligned
    exp_fetch.push_back(32'h00); exp_fetch.push_back(32'h04);
    release_reset();
    wait_halt(300);
    tick();
    chk("misalign_pc", imem_addr, 32'h04);
    chk("misalign_imem_req", {31'b0, imem_req}, 32'd0);
    end_phase();

    // Phase 4: reset while a load is stuck in MEM, then a clean rerun.
    dmem_hold = 1'b1;
    start_reset();
    imem[0] = i_type(0, 0, 2, 1, 'h03);        // lw x1,0(x0)
    exp_fetch.push_back(RST_PC);
    release_reset();
    n = 0;
    while (dmem_req !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("mem_reached", {31'b0, dmem_req}, 32'd1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("abort_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("abort_imem_req", {31'b0, imem_req}, 32'd0);
    chk("abort_pc", imem_addr, RST_PC);
    dmem_hold = 1'b0;
    end_phase();
    start_reset();
    imem[0] = i_type(77, 0, 0, 2, 'h13);       // addi x2,x0,77
    imem[1] = s_type(0, 2, 0);                 // sw   x2,0(x0)
    imem[2] = i_type(0, 0, 2, 1, 'h03);        // lw   x1,0(x0)
    imem[3] = s_type(40, 1, 0);                // sw   x1,40(x0)
    for (int a = 0; a <= 'h10; a += 4) exp_fetch.push_back(a);
    push_d(1, 0, 77, 1);
    push_d(0, 0, 0, 1);
    push_d(1, 40, 77, 1);
    release_reset();
    wait_halt(300);
    end_phase();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
